// File: rtl/fifo_uart_drain.sv
// fifo_uart_drain: pops words from the capture FIFO one at a time and
// transmits each one as a start/data/stop serial frame on the tx line.
module fifo_uart_drain #(
    parameter int DBITS        = 3,
    parameter int CLKS_PER_BIT = 434,
    parameter int RD_LAT       = 1
) (
    input  logic             SYS_CLK,
    input  logic             reset,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [DBITS-1:0] fifo_data,
    output logic             fifo_rd,
    output logic             tx,
    output logic             busy,
    output logic [15:0]      sent_count
);

    // Counter widths; single-value ranges still need at least one bit.
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DBITS > 1) ? $clog2(DBITS) : 1;
    localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DBITS - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(RD_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_bit_cnt;
    logic [IW-1:0]    r_bit_idx;
    logic [WW-1:0]    r_wait_cnt;
    logic [DBITS-1:0] r_shift;
    logic             r_fifo_rd;
    logic             r_tx;
    logic             r_busy;
    logic [15:0]      r_sent_count;
    logic             w_bit_done;

    // Last cycle of the current serial bit period.
    assign w_bit_done = (r_bit_cnt == BIT_LAST);

    assign fifo_rd    = r_fifo_rd;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign sent_count = r_sent_count;

    // Drain FSM: outputs are registered and updated together with the next state so
    // tx changes exactly once per bit boundary and never glitches.
    always_ff @(posedge SYS_CLK or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_bit_idx    <= '0;
            r_wait_cnt   <= '0;
            r_shift      <= '0;
            r_fifo_rd    <= 1'b0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_sent_count <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx      <= 1'b1;
                    r_bit_cnt <= '0;
                    if (enable && !fifo_empty) begin
                        // Strobe is raised here so it is high for exactly the REQ cycle.
                        r_state   <= ST_REQ;
                        r_fifo_rd <= 1'b1;
                        r_busy    <= 1'b1;
                    end else begin
                        r_state   <= ST_IDLE;
                        r_fifo_rd <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                end
                ST_REQ: begin
                    r_fifo_rd  <= 1'b0;
                    r_wait_cnt <= '0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // The pop is already committed; fifo_empty is not looked at here.
                    if (r_wait_cnt == WAIT_LAST) begin
                        r_shift   <= fifo_data;
                        r_tx      <= 1'b0;
                        r_bit_cnt <= '0;
                        r_state   <= ST_START;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_START: begin
                    if (w_bit_done) begin
                        r_bit_cnt <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1'b1;
                        r_state   <= ST_DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_done) begin
                        r_bit_cnt <= '0;
                        if (r_bit_idx == IDX_LAST) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1'b1;
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_bit_done) begin
                        r_bit_cnt    <= '0;
                        r_sent_count <= r_sent_count + 16'd1;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_fifo_rd <= 1'b0;
                    r_tx      <= 1'b1;
                    r_busy    <= 1'b0;
                    r_bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Self-checking bench for fifo_uart_drain (DBITS=8, CLKS_PER_BIT=4, RD_LAT=1).
// A small FIFO model feeds the DUT; expected frames are built from the pushed words.
module tb_fifo_uart_drain;

    localparam int DBITS = 8;
    localparam int CPB   = 4;
    localparam int RDL   = 1;
    localparam int FLEN  = (DBITS + 2) * CPB;

    logic             SYS_CLK = 1'b0;
    logic             reset;
    logic             enable;
    logic             force_empty;
    logic             fifo_empty;
    logic [DBITS-1:0] fifo_data = '0;
    logic             fifo_rd;
    logic             tx;
    logic             busy;
    logic [15:0]      sent_count;

    // FIFO model storage
    logic [DBITS-1:0] mem [0:63];
    int wr_ptr  = 0;
    int rd_ptr  = 0;
    int pops    = 0;
    int viol    = 0;
    logic prev_rd = 1'b0;

    int total    = 0;
    int bad      = 0;
    int exp_sent = 0;

    fifo_uart_drain #(.DBITS(DBITS), .CLKS_PER_BIT(CPB), .RD_LAT(RDL)) dut (
        .SYS_CLK    (SYS_CLK),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .busy       (busy),
        .sent_count (sent_count)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    assign fifo_empty = force_empty || (rd_ptr == wr_ptr);

    // FIFO read side: data valid one cycle after the pop; flag pops from an empty
    // model and pop strobes longer than one cycle.
    always @(posedge SYS_CLK) begin
        prev_rd <= fifo_rd;
        if (fifo_rd === 1'b1) begin
            pops <= pops + 1;
            if (rd_ptr == wr_ptr || prev_rd === 1'b1) viol <= viol + 1;
            if (rd_ptr != wr_ptr) begin
                fifo_data <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DBITS-1:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    // Wait for a start bit, then check every cycle of the frame against
    // {stop, data LSB first, start}; optionally drop enable at cycle drop_at.
    task automatic frame_check(input logic [DBITS-1:0] w, input int drop_at, input string tag);
        logic [DBITS+1:0] bits;
        int n;
        bits = {1'b1, w, 1'b0};
        n = 0;
        while (tx !== 1'b0 && n < 200) begin
            @(negedge SYS_CLK);
            n++;
        end
        chk({tag, "_start_seen"}, 32'(n < 200), 32'd1);
        for (int c = 0; c < FLEN; c++) begin
            if (c == drop_at) enable = 1'b0;
            chk($sformatf("%s_bit%0d_cyc%0d", tag, c / CPB, c % CPB), {31'd0, tx}, {31'd0, bits[c / CPB]});
            @(negedge SYS_CLK);
        end
        exp_sent++;
        chk({tag, "_sent"}, {16'd0, sent_count}, 32'(exp_sent));
        chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    endtask

    // Count idle-high cycles between a stop bit and the next start bit.
    task automatic gap_check(input string tag);
        int g;
        g = 0;
        while (tx === 1'b1 && g < 50) begin
            g++;
            @(negedge SYS_CLK);
        end
        chk({tag, "_gap"}, 32'(g), 32'(2 + RDL));
    endtask

    initial begin
        logic [DBITS-1:0] w1, w2;
        logic [DBITS-1:0] rw [0:5];
        int p0;

        // 1. Reset
        reset = 1'b1; enable = 1'b0; force_empty = 1'b0;
        repeat (3) @(posedge SYS_CLK);
        @(negedge SYS_CLK);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_rd", {31'd0, fifo_rd}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sent", {16'd0, sent_count}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge SYS_CLK);
        chk("idle_tx", {31'd0, tx}, 32'd1);

        // 2. Single word 0xA5
        p0 = pops;
        push(8'hA5);
        enable = 1'b1;
        frame_check(8'hA5, -1, "a5");
        chk("a5_pops", 32'(pops - p0), 32'd1);

        // 3. Three back-to-back words
        p0 = pops;
        push(8'h01); push(8'h80); push(8'hFF);
        frame_check(8'h01, -1, "w01");
        gap_check("w01_80");
        frame_check(8'h80, -1, "w80");
        gap_check("w80_ff");
        frame_check(8'hFF, -1, "wff");
        repeat (20) @(negedge SYS_CLK);
        chk("three_pops", 32'(pops - p0), 32'd3);
        chk("three_idle_tx", {31'd0, tx}, 32'd1);
        chk("three_idle_busy", {31'd0, busy}, 32'd0);

        // 4. enable dropped during DATA with two words queued
        w1 = 8'($urandom); w2 = 8'($urandom);
        p0 = pops;
        push(w1); push(w2);
        frame_check(w1, 3 * CPB, "drop");
        repeat (30) @(negedge SYS_CLK);
        chk("drop_pops", 32'(pops - p0), 32'd1);
        chk("drop_busy", {31'd0, busy}, 32'd0);
        chk("drop_sent", {16'd0, sent_count}, 32'(exp_sent));
        enable = 1'b1;
        frame_check(w2, -1, "reen");
        chk("reen_pops", 32'(pops - p0), 32'd2);

        // 5. Empty FIFO with enable high
        p0 = pops;
        for (int i = 0; i < 100; i++) begin
            @(negedge SYS_CLK);
            chk("empty_line", {29'd0, fifo_rd, tx, busy}, 32'b010);
        end
        chk("empty_pops", 32'(pops - p0), 32'd0);

        // 6. fifo_empty forced during WAIT
        w1 = 8'($urandom);
        push(w1);
        p0 = 0;
        while (fifo_rd !== 1'b1 && p0 < 20) begin
            @(negedge SYS_CLK);
            p0++;
        end
        chk("wait_req_seen", 32'(p0 < 20), 32'd1);
        @(negedge SYS_CLK);
        force_empty = 1'b1;
        frame_check(w1, -1, "wait_empty");
        force_empty = 1'b0;

        // 7. Random burst of six words
        p0 = pops;
        for (int i = 0; i < 6; i++) begin
            rw[i] = 8'($urandom);
            push(rw[i]);
        end
        for (int i = 0; i < 6; i++) begin
            frame_check(rw[i], -1, $sformatf("rnd%0d", i));
            if (i < 5) gap_check($sformatf("rnd%0d", i));
        end
        chk("rnd_pops", 32'(pops - p0), 32'd6);

        // 1b. Reset asserted in the middle of DATA
        push(8'h3C);
        p0 = 0;
        while (tx !== 1'b0 && p0 < 50) begin
            @(negedge SYS_CLK);
            p0++;
        end
        repeat (CPB + 6) @(negedge SYS_CLK);
        reset = 1'b1;
        #1;
        chk("mid_rst_tx", {31'd0, tx}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_sent", {16'd0, sent_count}, 32'd0);
        exp_sent = 0;
        repeat (2) @(negedge SYS_CLK);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge SYS_CLK);
            chk("post_rst_idle", {30'd0, tx, busy}, 32'b10);
        end

        chk("protocol_violations", 32'(viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
